wb_queue: RTL

Writeback queue sitting directly upstream of the register file write port. It collects completed results from two execution producers: port A (single-cycle ALU, priority) and port B (multi-cycle unit such as mul/div or load). It buffers them in program-completion order. It drains at most one result per cycle onto the register file's single write port (rw_ena/rw_addr/data_rw). Optionally it exposes pending results to operand fetch as a forwarding source.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_queue_if.sv | 31 +++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/wb_queue.sv | 136 +++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback queue.
package wb_pkg;

  localparam int unsigned WB_DEPTH  = 4;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  // Register r0 is hardwired to zero in the register file.
  localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Producer handshakes and register file write port of the writeback queue.
interface wb_queue_if import wb_pkg::*; #(
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DATA_W = WB_DATA_W
) ();

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  logic              rw_ena;
  logic [ADDR_W-1:0] rw_addr;
  logic [DATA_W-1:0] data_rw;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rw_ena, rw_addr, data_rw
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rw_ena, rw_addr, data_rw
  );

endinterface

// File: rtl/wb_fifo.sv
// Two-write/one-read circular buffer; exposes its contents for forwarding lookups.
module wb_fifo import wb_pkg::*; #(
  parameter  int unsigned DEPTH  = WB_DEPTH,
  parameter  int unsigned DATA_W = WB_DATA_W,
  parameter  int unsigned ADDR_W = WB_ADDR_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic                          wr0_en_i,
  input  logic [ADDR_W-1:0]             wr0_addr_i,
  input  logic [DATA_W-1:0]             wr0_data_i,
  input  logic                          wr1_en_i,
  input  logic [ADDR_W-1:0]             wr1_addr_i,
  input  logic [DATA_W-1:0]             wr1_data_i,
  input  logic                          rd_en_i,
  output logic [ADDR_W-1:0]             head_addr_o,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [CNT_W-1:0]              count_o,
  output logic [PTR_W-1:0]              rd_ptr_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_o,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data_o,
  output logic [DEPTH-1:0]              ent_valid_o
);

  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data_q;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [PTR_W-1:0]             wr1_slot_c;

  // Port 1 lands behind port 0 when both write, otherwise takes the tail slot.
  assign wr1_slot_c = wr_ptr_q + PTR_W'(wr0_en_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en_i) + PTR_W'(wr1_en_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
    count_d  = count_q + CNT_W'(wr0_en_i) + CNT_W'(wr1_en_i) - CNT_W'(rd_en_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en_i) begin
      mem_addr_q[wr_ptr_q] <= wr0_addr_i;
      mem_data_q[wr_ptr_q] <= wr0_data_i;
    end
    if (wr1_en_i) begin
      mem_addr_q[wr1_slot_c] <= wr1_addr_i;
      mem_data_q[wr1_slot_c] <= wr1_data_i;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    ent_valid_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_valid_o[i] = CNT_W'(PTR_W'(i) - rd_ptr_q) < count_q;
    end
  end

  assign head_addr_o = mem_addr_q[rd_ptr_q];
  assign head_data_o = mem_data_q[rd_ptr_q];
  assign count_o     = count_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign ent_addr_o  = mem_addr_q;
  assign ent_data_o  = mem_data_q;

endmodule

// File: rtl/wb_queue.sv
// Writeback queue in front of the register file write port.
// Optional forwarding of pending results is built when WB_QUEUE_FWD_EN is defined.
module wb_queue import wb_pkg::*; #(
  parameter  int unsigned DEPTH  = WB_DEPTH,
  parameter  int unsigned DATA_W = WB_DATA_W,
  parameter  int unsigned ADDR_W = WB_ADDR_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  wb_queue_if.slave         bus,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] q0_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  output logic              q0_hit,
  output logic              q1_hit,
  output logic [DATA_W-1:0] q0_data,
  output logic [DATA_W-1:0] q1_data
);

  logic [CNT_W-1:0]             free_c;
  logic                         a_ready_c, b_ready_c;
  logic                         enq_a_c, enq_b_c, deq_c;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [PTR_W-1:0]             rd_ptr;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]             ent_valid;
  logic                         rw_ena_q;
  logic [ADDR_W-1:0]            rw_addr_q;
  logic [DATA_W-1:0]            data_rw_q;

  // B needs room behind a possible A transfer; same-cycle pops are not credited.
  always_comb begin
    free_c    = CNT_W'(DEPTH) - count;
    a_ready_c = rst && (free_c >= CNT_W'(1));
    b_ready_c = rst && (bus.a_valid ? (free_c >= CNT_W'(2)) : (free_c >= CNT_W'(1)));
    enq_a_c   = bus.a_valid && a_ready_c && (bus.a_addr != ADDR_W'(ZERO_REG));
    enq_b_c   = bus.b_valid && b_ready_c && (bus.b_addr != ADDR_W'(ZERO_REG));
    deq_c     = ena && !empty;
  end

  assign bus.a_ready = a_ready_c;
  assign bus.b_ready = b_ready_c;
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .wr0_en_i    (enq_a_c),
    .wr0_addr_i  (bus.a_addr),
    .wr0_data_i  (bus.a_data),
    .wr1_en_i    (enq_b_c),
    .wr1_addr_i  (bus.b_addr),
    .wr1_data_i  (bus.b_data),
    .rd_en_i     (deq_c),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count),
    .rd_ptr_o    (rd_ptr),
    .ent_addr_o  (ent_addr),
    .ent_data_o  (ent_data),
    .ent_valid_o (ent_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rw_ena_q  <= 1'b0;
      rw_addr_q <= '0;
      data_rw_q <= '0;
    end else begin
      rw_ena_q <= deq_c;
      if (deq_c) begin
        rw_addr_q <= head_addr;
        data_rw_q <= head_data;
      end
    end
  end

  assign bus.rw_ena  = rw_ena_q;
  assign bus.rw_addr = rw_addr_q;
  assign bus.data_rw = data_rw_q;

`ifdef WB_QUEUE_FWD_EN
  logic [1:0][ADDR_W-1:0] q_addr_c;
  logic [1:0]             q_hit_c;
  logic [1:0][DATA_W-1:0] q_data_c;

  assign q_addr_c = {q1_addr, q0_addr};

  // Scan oldest to newest so the youngest matching producer overrides.
  always_comb begin
    q_hit_c  = '0;
    q_data_c = '0;
    for (int p = 0; p < 2; p++) begin
      if (q_addr_c[p] != ADDR_W'(ZERO_REG)) begin
        if (rw_ena_q && (rw_addr_q == q_addr_c[p])) begin
          q_hit_c[p]  = 1'b1;
          q_data_c[p] = data_rw_q;
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
          if (ent_valid[PTR_W'(rd_ptr + PTR_W'(k))] &&
              (ent_addr[PTR_W'(rd_ptr + PTR_W'(k))] == q_addr_c[p])) begin
            q_hit_c[p]  = 1'b1;
            q_data_c[p] = ent_data[PTR_W'(rd_ptr + PTR_W'(k))];
          end
        end
      end
    end
  end

  assign q0_hit  = q_hit_c[0];
  assign q1_hit  = q_hit_c[1];
  assign q0_data = q_data_c[0];
  assign q1_data = q_data_c[1];
`else
  logic unused_fwd;

  assign unused_fwd = ^{q0_addr, q1_addr, rd_ptr, ent_addr, ent_data, ent_valid};
  assign q0_hit     = 1'b0;
  assign q1_hit     = 1'b0;
  assign q0_data    = '0;
  assign q1_data    = '0;
`endif

endmodule
